// File: rtl/icg_enable_ctrl.sv
// icg_enable_ctrl: functional enable generator for a latch-based clock gate.
// Wake handshake, idle hysteresis and scan-enable pass-through.
module icg_enable_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic             HOLD,
  input  logic             SE,
  output logic             E,
  output logic             TE,
  output logic             ACK,
  output logic             GATED,
  output logic [CNT_W-1:0] CNT
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [CNT_W-1:0] WAKE_LAST =
    CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST =
    CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  if (CNT_W < 1) begin : g_bad_w
    $error("icg_enable_ctrl: CNT_W must be >= 1");
  end
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > CNT_MAX)
  begin : g_bad_idle
    $error("icg_enable_ctrl: IDLE_CYCLES out of range");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > CNT_MAX)
  begin : g_bad_wake
    $error("icg_enable_ctrl: WAKE_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    S_OFF,
    S_WAKE,
    S_ON,
    S_DRAIN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             act;

  // Scan path bypasses the FSM so test clocks never wait on state.
  assign TE  = SE;
  assign act = REQ | HOLD;

  // Next-state and shared counter; a wake always completes.
  always_comb begin
    state_nx = state;
    cnt_nx   = CNT;
    unique case (state)
      S_OFF: begin
        if (act) begin
          state_nx = S_WAKE;
          cnt_nx   = CNT_ZERO;
        end
      end
      S_WAKE: begin
        if (CNT == WAKE_LAST) begin
          state_nx = S_ON;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx = CNT + CNT_ONE;
        end
      end
      S_ON: begin
        if (!act) begin
          state_nx = S_DRAIN;
          cnt_nx   = CNT_ZERO;
        end
      end
      S_DRAIN: begin
        if (act) begin
          state_nx = S_ON;
          cnt_nx   = CNT_ZERO;
        end else if (CNT == IDLE_LAST) begin
          state_nx = S_OFF;
          cnt_nx   = CNT_ZERO;
        end else begin
          cnt_nx = CNT + CNT_ONE;
        end
      end
      default: begin
        state_nx = S_OFF;
        cnt_nx   = CNT_ZERO;
      end
    endcase
  end

  // Outputs decoded from next state so E changes only at CLK rise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_OFF;
      CNT   <= '0;
      E     <= 1'b0;
      ACK   <= 1'b0;
      GATED <= 1'b1;
    end else begin
      state <= state_nx;
      CNT   <= cnt_nx;
      E     <= (state_nx != S_OFF);
      ACK   <= (state_nx == S_ON);
      GATED <= (state_nx == S_OFF);
    end
  end

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// tb_icg_enable_ctrl: directed and random checks of icg_enable_ctrl
// against a timestamp-based behavioural model.
module tb_icg_enable_ctrl;

  localparam int IDLE = 8;
  localparam int WAKE = 2;
  localparam int W    = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         REQ = 1'b0;
  logic         HOLD = 1'b0;
  logic         SE = 1'b0;
  logic         E;
  logic         TE;
  logic         ACK;
  logic         GATED;
  logic [W-1:0] CNT;

  int n_tests = 0;
  int n_fail  = 0;

  // model: gate enabled, ack granted, waking, timestamps
  bit m_e;
  bit m_ack;
  bit m_waking;
  int m_t0;
  int m_cnt;
  int t;

  icg_enable_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE),
    .CNT_W(W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ(REQ),
    .HOLD(HOLD),
    .SE(SE),
    .E(E),
    .TE(TE),
    .ACK(ACK),
    .GATED(GATED),
    .CNT(CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W+2:0] expv();
    return {m_e, m_ack, ~m_e, W'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_e = 0;
    m_ack = 0;
    m_waking = 0;
    m_cnt = 0;
    m_t0 = 0;
  endtask

  // Reference: ack WAKE edges after enable; off IDLE edges after
  // the last active edge; CNT is elapsed edges in the phase.
  task automatic model_edge(input bit act);
    t++;
    if (!m_e) begin
      if (act) begin
        m_e = 1;
        m_waking = 1;
        m_t0 = t;
        m_cnt = 0;
      end
    end else if (m_waking) begin
      if (t - m_t0 == WAKE) begin
        m_waking = 0;
        m_ack = 1;
        m_cnt = 0;
      end else m_cnt = t - m_t0;
    end else if (m_ack) begin
      if (!act) begin
        m_ack = 0;
        m_t0 = t;
        m_cnt = 0;
      end
    end else begin
      if (act) begin
        m_ack = 1;
        m_cnt = 0;
      end else if (t - m_t0 == IDLE) begin
        m_e = 0;
        m_cnt = 0;
      end else m_cnt = t - m_t0;
    end
  endtask

  task automatic tick(input bit req, input bit hold);
    REQ = req;
    HOLD = hold;
    @(posedge CLK);
    model_edge(req | hold);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    REQ = 0;
    HOLD = 0;
    RST = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if ({E, ACK, GATED, CNT} !== {2'b00, 1'b1, W'(0)}) begin
      n_fail++;
      $display("FAIL reset_vals got=%b exp=%b",
        {E, ACK, GATED, CNT}, {2'b00, 1'b1, W'(0)});
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      SE = 1'($urandom);
      #1;
      n_tests++;
      if (TE !== SE) begin
        n_fail++;
        $display("FAIL idle_te got=%b exp=%b", TE, SE);
      end
      tick(0, 0);
      n_tests++;
      if ({E, ACK, GATED, CNT} !== {2'b00, 1'b1, W'(0)}) begin
        n_fail++;
        $display("FAIL idle_out cyc=%0d got=%b", i,
          {E, ACK, GATED, CNT});
      end
    end
    SE = 0;
  endtask

  task automatic test_wake();
    tick(1, 0);
    n_tests++;
    if ({E, ACK, GATED} !== 3'b100) begin
      n_fail++;
      $display("FAIL wake_e1 got=%b exp=100", {E, ACK, GATED});
    end
    tick(1, 0);
    n_tests++;
    if ({E, ACK, CNT} !== {2'b10, W'(1)}) begin
      n_fail++;
      $display("FAIL wake_e2 got=%b", {E, ACK, CNT});
    end
    tick(1, 0);
    n_tests++;
    if ({E, ACK, GATED, CNT} !== expv() || ACK !== 1'b1) begin
      n_fail++;
      $display("FAIL wake_ack got=%b exp=%b",
        {E, ACK, GATED, CNT}, expv());
    end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < IDLE; i++) begin
      tick(0, 0);
      n_tests++;
      if (ACK !== 1'b0 || E !== 1'b1 || CNT !== W'(i)) begin
        n_fail++;
        $display("FAIL hyst_cnt i=%0d got=%b%b cnt=%0d", i,
          E, ACK, CNT);
      end
    end
    tick(0, 0);
    n_tests++;
    if ({E, GATED, CNT} !== {2'b01, W'(0)} ||
        {E, ACK, GATED, CNT} !== expv()) begin
      n_fail++;
      $display("FAIL hyst_off got=%b exp=%b",
        {E, ACK, GATED, CNT}, expv());
    end
  endtask

  task automatic test_redrain();
    tick(1, 0);
    tick(1, 0);
    tick(1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0);
      n_tests++;
      if (E !== 1'b1 || ACK !== 1'b0) begin
        n_fail++;
        $display("FAIL redrain_drain i=%0d got=%b%b", i, E, ACK);
      end
    end
    tick(1, 0);
    n_tests++;
    if ({E, ACK, GATED, CNT} !== {3'b110, W'(0)}) begin
      n_fail++;
      $display("FAIL redrain_on got=%b",
        {E, ACK, GATED, CNT});
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      tick(0, 1);
      n_tests++;
      if ({E, ACK, GATED, CNT} !== expv() ||
          (i >= WAKE && ACK !== 1'b1)) begin
        n_fail++;
        $display("FAIL hold_on i=%0d got=%b exp=%b", i,
          {E, ACK, GATED, CNT}, expv());
      end
    end
    for (int i = 0; i <= IDLE; i++) tick(0, 0);
    n_tests++;
    if ({E, GATED} !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_off got=%b exp=01", {E, GATED});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1, 0);
    tick(1, 0);
    n_tests++;
    if (CNT !== W'(1) || E !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre got cnt=%0d e=%b", CNT, E);
    end
    #2;
    RST = 1'b1;
    #1;
    n_tests++;
    if ({E, ACK, GATED, CNT} !== {3'b001, W'(0)}) begin
      n_fail++;
      $display("FAIL arst_now got=%b", {E, ACK, GATED, CNT});
    end
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < WAKE + 1; i++) begin
      tick(1, 0);
      n_tests++;
      if ({E, ACK, GATED, CNT} !== expv()) begin
        n_fail++;
        $display("FAIL arst_wake i=%0d got=%b exp=%b", i,
          {E, ACK, GATED, CNT}, expv());
      end
    end
    n_tests++;
    if (ACK !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_ack got=%b exp=1", ACK);
    end
  endtask

  task automatic test_random();
    bit r;
    bit h;
    int bias;
    for (int i = 0; i < 600; i++) begin
      bias = (i / 50) % 3;
      r = ($urandom_range(0, 9) < 3 * bias + 1);
      h = ($urandom_range(0, 19) == 0);
      SE = 1'($urandom);
      tick(r, h);
      n_tests++;
      if ({E, ACK, GATED, CNT} !== expv() || TE !== SE) begin
        n_fail++;
        $display("FAIL rand i=%0d got=%b te=%b exp=%b se=%b", i,
          {E, ACK, GATED, CNT}, TE, expv(), SE);
      end
    end
    SE = 0;
  endtask

  initial begin
    t = 0;
    model_reset();
    test_reset();
    test_idle();
    test_wake();
    test_hysteresis();
    test_redrain();
    test_hold();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
